// File: rtl/fibo_pkg.sv
// rtl/fibo_pkg.sv - shared widths and state encoding for the fibonacci BCD converter
package fibo_pkg;

  localparam int DATA_W = 16;
  localparam int DIGITS = 5;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/fibo_bcd_conv.sv
// rtl/fibo_bcd_conv.sv - sequential binary-to-BCD converter with one-entry holding register
module fibo_bcd_conv #(
  parameter int DATA_W = fibo_pkg::DATA_W,
  parameter int DIGITS = fibo_pkg::DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic                  overflow
);
  import fibo_pkg::*;

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              bcd_valid_q, bcd_valid_d;
  logic              ovf_q, ovf_d;

  logic [BW-1:0]     acc_adj;
  logic [BW-1:0]     acc_step;
  logic [DATA_W-1:0] bin_step;
  logic              accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (acc_adj[4*g +: 4])
    );
  end

  // The top adjusted bit falls off the shift; it is always zero when 10^DIGITS > 2^DATA_W-1.
  always_comb begin
    {acc_step, bin_step} = {acc_adj, bin_q} << 1;
  end

  assign accept = in_valid & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    ovf_d       = ovf_q | (in_valid & hold_full_q);

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          bin_d   = in_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d = acc_step;
        bin_d = bin_step;
        cnt_d = cnt_q + 1'b1;
        if (accept) begin
          hold_d      = in_data;
          hold_full_d = 1'b1;
        end
        if (cnt_q == CNT_LAST) begin
          bcd_d       = acc_step;
          bcd_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (hold_full_q) begin
          bin_d       = hold_q;
          acc_d       = '0;
          cnt_d       = '0;
          hold_full_d = 1'b0;
          state_d     = S_SHIFT;
        end else if (accept) begin
          bin_d   = in_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = ~hold_full_q;
  assign bcd_out   = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = (state_q == S_SHIFT);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fibo_bcd_conv.sv
// tb/tb_fibo_bcd_conv.sv - scoreboard bench for fibo_bcd_conv
module tb_fibo_bcd_conv;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic [19:0] bcd_out;
  logic        bcd_valid;
  logic        busy;
  logic        overflow;

  fibo_bcd_conv dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // due == 0 means the result order is checked but not its arrival cycle
  always @(negedge clock) begin
    exp_t e;
    if (bcd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got bcd_out=%0h with no result pending (cycle %0d)", bcd_out, cyc);
      end else begin
        e = sb.pop_front();
        check("bcd_out", bcd_out, e.val);
        if (e.due != 0) check("latency_cycle", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due != 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_valid: got no bcd_valid, expected %0h at cycle %0d", e.val, e.due);
    end
  end

  task automatic send(input logic [15:0] v, input logic [19:0] exp, input int due_off);
    exp_t e;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = v;
    if (due_off > 0) begin
      e.val = exp;
      e.due = cyc + due_off;
      sb.push_back(e);
    end
    @(posedge clock);
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && sb.size() > 0; k++) @(negedge clock);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  logic [15:0] fib_v [12] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5,
                              16'd8, 16'd13, 16'd21, 16'd34, 16'd55, 16'd89};
  logic [19:0] fib_e [12] = '{20'h00000, 20'h00001, 20'h00001, 20'h00002, 20'h00003, 20'h00005,
                              20'h00008, 20'h00013, 20'h00021, 20'h00034, 20'h00055, 20'h00089};

  initial begin
    exp_t e;
    int   idx;
    bit   took;

    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'd123;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    check("rst_bcd_out", bcd_out, 20'h0);
    check("rst_bcd_valid", bcd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    send(16'd0, 20'h00000, 17);
    idle();
    check("busy_shift", busy, 1'b1);
    drain();
    check("busy_idle", busy, 1'b0);
    send(16'd55, 20'h00055, 17);
    idle();
    drain();
    send(16'd46368, 20'h46368, 17);
    idle();
    drain();
    send(16'd65535, 20'h65535, 17);
    idle();
    drain();
    check("hold_last_result", bcd_out, 20'h65535);

    send(16'd34, 20'h00034, 17);
    send(16'd55, 20'h00055, 33);
    idle();
    check("b2b_in_ready_full", in_ready, 1'b0);
    drain();
    check("b2b_overflow", overflow, 1'b0);

    send(16'd1, 20'h00001, 17);
    send(16'd2, 20'h00002, 33);
    @(negedge clock);
    check("drop_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 16'd3;
    @(posedge clock);
    idle();
    check("drop_overflow", overflow, 1'b1);
    drain();
    check("drop_overflow_sticky", overflow, 1'b1);

    send(16'd4181, 20'h04181, -1);
    idle();
    repeat (6) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_overflow", overflow, 1'b0);
    check("midrst_bcd_out", bcd_out, 20'h0);
    check("midrst_in_ready", in_ready, 1'b1);
    repeat (20) @(negedge clock);
    send(16'd6765, 20'h06765, 17);
    idle();
    drain();

    idx = 0;
    for (int k = 0; k < 1000 && idx < 12; k++) begin
      @(negedge clock);
      took     = in_ready;
      in_valid = in_ready;
      in_data  = fib_v[idx];
      if (took) begin
        e.val = fib_e[idx];
        e.due = 0;
        sb.push_back(e);
      end
      @(posedge clock);
      if (took) idx++;
    end
    idle();
    check("chain_terms_sent", idx, 12);
    drain();
    check("chain_overflow", overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
